lsu_mem_port: RTL and testbench

Load/store initiator that drives one port of the dual-port main memory on behalf of the pipeline's memory stage. Accepts byte/half/word load and store requests at any byte address and converts them into one or two word-aligned memory accesses with byte-lane enables. Handles the memory's one-cycle registered read latency and returns aligned, zero- or sign-extended load data. Instantiated once per port, on the data port.

---
 rtl/lsu_mem_port.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_port.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store initiator for one main-memory port: splits unaligned byte/half/word
// requests into one or two word-aligned accesses and assembles extended load data.
module lsu_mem_port #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data_o,
  output logic [3:0]            mem_data_en,
  output logic                  mem_write_en,
  input  logic [31:0]           mem_data_i
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, RDWAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  write_q, signed_q, split_q;
  logic [1:0]            size_q, off_q;
  logic [3:0]            en1_q;
  logic [31:0]           w0_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [3:0]            mem_en_q;
  logic                  mem_we_q;
  logic [31:0]           rdata_q;

  logic                  accept;
  logic [3:0]            nmask;
  logic [7:0]            lane_mask;
  logic [5:0]            wsh;
  logic [31:0]           wrot;
  logic [55:0]           both;
  logic [31:0]           aligned;
  logic [31:0]           load_res;

  assign req_ready    = (state_q == IDLE) && !reset;
  assign accept       = req_valid && req_ready;
  assign resp_valid   = (state_q == RESP);
  assign resp_rdata   = rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_o   = mem_wdata_q;
  assign mem_data_en  = mem_en_q;
  assign mem_write_en = mem_we_q;

  // Request decode: lanes spilling past bit 3 of the 8-lane mask belong to access 1.
  always_comb begin
    unique case (req_size)
      2'b00:   nmask = 4'b0001;
      2'b01:   nmask = 4'b0011;
      default: nmask = 4'b1111;
    endcase
    lane_mask = {4'b0000, nmask} << req_addr[1:0];
    wsh       = {1'b0, req_addr[1:0], 3'b000};
    wrot      = (req_wdata << wsh) | (req_wdata >> (6'd32 - wsh));
  end

  // Load assembly; the top byte of w1 can never be part of a split result.
  always_comb begin
    both = split_q ? {mem_data_i[23:0], w0_q} : {24'h000000, mem_data_i};
    unique case (off_q)
      2'd0:    aligned = both[31:0];
      2'd1:    aligned = both[39:8];
      2'd2:    aligned = both[47:16];
      default: aligned = both[55:24];
    endcase
    unique case (size_q)
      2'b00:   load_res = {{24{signed_q & aligned[7]}}, aligned[7:0]};
      2'b01:   load_res = {{16{signed_q & aligned[15]}}, aligned[15:0]};
      default: load_res = aligned;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACC0;
      ACC0:    state_d = split_q ? ACC1 : (write_q ? RESP : RDWAIT);
      ACC1:    state_d = write_q ? RESP : RDWAIT;
      RDWAIT:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      split_q     <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      en1_q       <= '0;
      w0_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_en_q    <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      mem_en_q <= '0;
      mem_we_q <= 1'b0;
      unique case (state_q)
        IDLE: if (accept) begin
          write_q     <= req_write;
          signed_q    <= req_signed;
          size_q      <= req_size;
          off_q       <= req_addr[1:0];
          split_q     <= |lane_mask[7:4];
          en1_q       <= lane_mask[7:4];
          mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_q <= wrot;
          mem_en_q    <= lane_mask[3:0];
          mem_we_q    <= req_write;
        end
        ACC0: begin
          if (split_q) begin
            mem_addr_q <= mem_addr_q + ADDR_WIDTH'(4);
            mem_en_q   <= en1_q;
            mem_we_q   <= write_q;
          end else if (write_q) begin
            rdata_q <= '0;
          end
        end
        ACC1: begin
          if (write_q) rdata_q <= '0;
          else         w0_q    <= mem_data_i;
        end
        RDWAIT:  rdata_q <= load_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a registered-read word memory model.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [13:0] mem_addr;
  logic [31:0] mem_data_o, mem_data_i;
  logic [3:0]  mem_data_en;
  logic        mem_write_en;

  int n_cmp = 0;
  int n_err = 0;

  lsu_mem_port #(.ADDR_WIDTH(14)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_data_o(mem_data_o), .mem_data_en(mem_data_en),
    .mem_write_en(mem_write_en), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic [31:0] rd_q = '0;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_write_en && mem_data_en[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
    rd_q <= mem[mem_addr[13:2]];
  end
  assign mem_data_i = rd_q;

  int          n_acc, resp_k, busy_rdy;
  logic [13:0] a_addr [0:1];
  logic [3:0]  a_en   [0:1];
  logic [31:0] a_data [0:1];
  logic        a_we   [0:1];
  logic [31:0] r_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [13:0] ad, input logic [31:0] wd);
    int waitc;
    n_acc = 0; resp_k = 0; busy_rdy = 0; r_data = '0;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (req_ready) busy_rdy++;
      if (mem_data_en != 4'b0000) begin
        if (n_acc < 2) begin
          a_addr[n_acc] = mem_addr; a_en[n_acc] = mem_data_en;
          a_data[n_acc] = mem_data_o; a_we[n_acc] = mem_write_en;
        end
        n_acc++;
      end
      if (resp_valid) begin
        resp_k = k;
        r_data = resp_rdata;
        break;
      end
    end
  endtask

  task automatic exp_txn(input string t, input int nacc, input int k, input logic [31:0] rd);
    chk({t, ".nacc"}, n_acc, nacc);
    chk({t, ".lat"}, resp_k, k);
    chk({t, ".rdata"}, r_data, rd);
    chk({t, ".busy_rdy"}, busy_rdy, 0);
  endtask

  task automatic exp_acc(input string t, input int i, input logic [13:0] ad, input logic [3:0] en,
                         input logic we, input logic [31:0] d);
    chk({t, ".addr"}, 32'(a_addr[i]), 32'(ad));
    chk({t, ".en"}, 32'(a_en[i]), 32'(en));
    chk({t, ".we"}, 32'(a_we[i]), 32'(we));
    if (we) chk({t, ".wdata"}, a_data[i], d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accs, resps;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 0);
    chk("rst.resp_valid", 32'(resp_valid), 0);
    chk("rst.rdata", resp_rdata, 0);
    chk("rst.addr", 32'(mem_addr), 0);
    chk("rst.wdata", mem_data_o, 0);
    chk("rst.en", 32'(mem_data_en), 0);
    chk("rst.we", 32'(mem_write_en), 0);
    reset = 1'b0;
    #1 chk("rst.ready_rel", 32'(req_ready), 1);

    txn(1'b1, 2'b10, 1'b0, 14'h0010, 32'hDEADBEEF);
    exp_txn("sw10", 1, 2, 32'h0); exp_acc("sw10.a0", 0, 14'h0010, 4'b1111, 1'b1, 32'hDEADBEEF);
    txn(1'b0, 2'b10, 1'b0, 14'h0010, 32'h0);
    exp_txn("lw10", 1, 3, 32'hDEADBEEF); exp_acc("lw10.a0", 0, 14'h0010, 4'b1111, 1'b0, 32'h0);
    txn(1'b1, 2'b10, 1'b0, 14'h0010, 32'h80FF0000);
    exp_txn("sw10b", 1, 2, 32'h0); exp_acc("sw10b.a0", 0, 14'h0010, 4'b1111, 1'b1, 32'h80FF0000);
    txn(1'b0, 2'b00, 1'b1, 14'h0013, 32'h0);
    exp_txn("lbs13", 1, 3, 32'hFFFFFF80); exp_acc("lbs13.a0", 0, 14'h0010, 4'b1000, 1'b0, 32'h0);
    txn(1'b0, 2'b00, 1'b0, 14'h0013, 32'h0);
    exp_txn("lbu13", 1, 3, 32'h00000080);
    txn(1'b0, 2'b01, 1'b1, 14'h0012, 32'h0);
    exp_txn("lhs12", 1, 3, 32'hFFFF80FF); exp_acc("lhs12.a0", 0, 14'h0010, 4'b1100, 1'b0, 32'h0);
    txn(1'b0, 2'b11, 1'b0, 14'h0010, 32'h0);
    exp_txn("lrsv10", 1, 3, 32'h80FF0000); exp_acc("lrsv10.a0", 0, 14'h0010, 4'b1111, 1'b0, 32'h0);

    // Continuous req_valid: one request every 4 cycles, each answered exactly once.
    accs = 0; resps = 0;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 14'h0010; req_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      if (resp_valid) begin
        resps++;
        chk("hold.rdata", resp_rdata, 32'h80FF0000);
        chk("hold.ready_in_resp", 32'(req_ready), 0);
      end
      if (req_valid && req_ready) accs++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) resps++;
    end
    chk("hold.accepts", accs, 6);
    chk("hold.resps", resps, 6);

    txn(1'b1, 2'b01, 1'b0, 14'h0007, 32'h0000ABCD);
    exp_txn("sh07", 2, 3, 32'h0);
    exp_acc("sh07.a0", 0, 14'h0004, 4'b1000, 1'b1, 32'hCD0000AB);
    exp_acc("sh07.a1", 1, 14'h0008, 4'b0001, 1'b1, 32'hCD0000AB);
    txn(1'b0, 2'b01, 1'b0, 14'h0007, 32'h0);
    exp_txn("lhu07", 2, 4, 32'h0000ABCD);
    exp_acc("lhu07.a0", 0, 14'h0004, 4'b1000, 1'b0, 32'h0);
    exp_acc("lhu07.a1", 1, 14'h0008, 4'b0001, 1'b0, 32'h0);
    txn(1'b0, 2'b01, 1'b1, 14'h0007, 32'h0);
    exp_txn("lhs07", 2, 4, 32'hFFFFABCD);
    txn(1'b1, 2'b10, 1'b0, 14'h3FFD, 32'h11223344);
    exp_txn("swwrap", 2, 3, 32'h0);
    exp_acc("swwrap.a0", 0, 14'h3FFC, 4'b1110, 1'b1, 32'h22334411);
    exp_acc("swwrap.a1", 1, 14'h0000, 4'b0001, 1'b1, 32'h22334411);
    txn(1'b0, 2'b10, 1'b1, 14'h3FFD, 32'h0);
    exp_txn("lwwrap", 2, 4, 32'h11223344);
    exp_acc("lwwrap.a0", 0, 14'h3FFC, 4'b1110, 1'b0, 32'h0);
    exp_acc("lwwrap.a1", 1, 14'h0000, 4'b0001, 1'b0, 32'h0);
    txn(1'b0, 2'b00, 1'b0, 14'h0000, 32'h0);
    exp_txn("lbu00", 1, 3, 32'h00000011);
    txn(1'b1, 2'b00, 1'b0, 14'h0012, 32'hFFFFFF5A);
    exp_txn("sb12", 1, 2, 32'h0); exp_acc("sb12.a0", 0, 14'h0010, 4'b0100, 1'b1, 32'hFF5AFFFF);
    txn(1'b0, 2'b10, 1'b0, 14'h0010, 32'h0);
    exp_txn("lw10c", 1, 3, 32'h805A0000);

    // Reset asserted while access 1 of a split load is on the port.
    @(negedge clk);
    req_write = 1'b0; req_size = 2'b01; req_signed = 1'b0; req_addr = 14'h0007; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid.ready", 32'(req_ready), 0);
    chk("mid.resp_valid", 32'(resp_valid), 0);
    chk("mid.rdata", resp_rdata, 0);
    chk("mid.addr", 32'(mem_addr), 0);
    chk("mid.wdata", mem_data_o, 0);
    chk("mid.en", 32'(mem_data_en), 0);
    chk("mid.we", 32'(mem_write_en), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    resps = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) resps++;
    end
    chk("mid.no_resp", resps, 0);
    chk("mid.ready_after", 32'(req_ready), 1);
    txn(1'b0, 2'b01, 1'b0, 14'h0007, 32'h0);
    exp_txn("post_rst", 2, 4, 32'h0000ABCD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
